// File: rtl/mips32_pkg.sv
// Shared MIPS32 pipeline types: opcodes, instruction field positions and writeback source select.
package mips32_pkg;

  localparam int unsigned IR_W   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 32;

  localparam int unsigned OP_MSB  = 31;
  localparam int unsigned OP_LSB  = 26;
  localparam int unsigned RD_MSB  = 25;
  localparam int unsigned RD_LSB  = 21;
  localparam int unsigned RS1_MSB = 20;
  localparam int unsigned RS1_LSB = 16;
  localparam int unsigned RS2_MSB = 15;
  localparam int unsigned RS2_LSB = 11;

  typedef enum logic [5:0] {
    OP_ADD  = 6'h00,
    OP_SUB  = 6'h01,
    OP_AND  = 6'h02,
    OP_OR   = 6'h03,
    OP_SLT  = 6'h04,
    OP_MUL  = 6'h05,
    OP_LW   = 6'h08,
    OP_SW   = 6'h09,
    OP_ADDI = 6'h0A,
    OP_SUBI = 6'h0B,
    OP_SLTI = 6'h0C,
    OP_BNEZ = 6'h0D,
    OP_BEQZ = 6'h0E,
    OP_JAL  = 6'h10,
    OP_HLT  = 6'h3F
  } opcode_t;

  typedef enum logic [1:0] {
    WB_ALU,
    WB_LMD,
    WB_NPC,
    WB_NONE
  } wb_sel_t;

  // Writeback source for a retiring opcode; stores, branches, HLT and unknowns write nothing.
  function automatic wb_sel_t wb_sel_of(input opcode_t op);
    wb_sel_t sel;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL,
      OP_ADDI, OP_SUBI, OP_SLTI: sel = WB_ALU;
      OP_LW:                     sel = WB_LMD;
      OP_JAL:                    sel = WB_NPC;
      default:                   sel = WB_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/writeback_regfile_if.sv
// MEM/WB boundary bus carrying a retiring instruction into the writeback stage.
interface writeback_regfile_if #(
  parameter int unsigned XLEN = 32
);
  logic            wb_valid;
  logic [31:0]     ir_wb;
  logic [XLEN-1:0] alu_out_wb;
  logic [XLEN-1:0] lmd_wb;
  logic [XLEN-1:0] npc_wb;

  modport master (output wb_valid, ir_wb, alu_out_wb, lmd_wb, npc_wb);
  modport slave  (input  wb_valid, ir_wb, alu_out_wb, lmd_wb, npc_wb);
endinterface

// File: rtl/regbank_3r1w.sv
// 32 x XLEN architectural register bank: one registered write port, three combinational reads.
// Define WB_BYPASS_EN to forward the pending write to matching read ports.
module regbank_3r1w
  import mips32_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [REG_AW-1:0] raddr0,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [XLEN-1:0]   rdata0,
  output logic [XLEN-1:0]   rdata1,
  output logic [XLEN-1:0]   rdata2
);

  logic [XLEN-1:0]   mem [NREG];
  logic [REG_AW-1:0] raddr [3];
  logic [XLEN-1:0]   rdata [3];

  // Reset takes priority so a write pending at reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign raddr[0] = raddr0;
  assign raddr[1] = raddr1;
  assign raddr[2] = raddr2;

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rdata[p] = (raddr[p] == '0) ? '0 : mem[raddr[p]];
`ifdef WB_BYPASS_EN
      if (we && (waddr == raddr[p]) && (raddr[p] != '0)) rdata[p] = wdata;
`endif
    end
  end

  assign rdata0 = rdata[0];
  assign rdata1 = rdata[1];
  assign rdata2 = rdata[2];

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: classifies retiring instructions, stages the write, tracks halt and retire count.
// Optional write-through read bypass is enabled with `define WB_BYPASS_EN (see regbank_3r1w).
module writeback_regfile
  import mips32_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  writeback_regfile_if.slave wb,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  input  logic [REG_AW-1:0] rd_addr,
  output logic [XLEN-1:0]   a_data,
  output logic [XLEN-1:0]   b_data,
  output logic [XLEN-1:0]   d_data,
  output logic              wr_en,
  output logic [REG_AW-1:0] wr_addr,
  output logic [XLEN-1:0]   wr_data,
  output logic              halted,
  output logic [CNT_W-1:0]  retired_cnt
);

  opcode_t           op;
  wb_sel_t           sel;
  logic [REG_AW-1:0] rd;
  logic [XLEN-1:0]   src_data;
  logic              capture;
  logic              do_write;
  logic              unused_ir;

  assign unused_ir = ^wb.ir_wb[RS1_MSB:0];

  // Decode the retiring instruction and pick its writeback value.
  always_comb begin
    op       = opcode_t'(wb.ir_wb[OP_MSB:OP_LSB]);
    rd       = wb.ir_wb[RD_MSB:RD_LSB];
    sel      = wb_sel_of(op);
    capture  = wb.wb_valid && !halted;
    src_data = wb.alu_out_wb;
    case (sel)
      WB_LMD:  src_data = wb.lmd_wb;
      WB_NPC:  src_data = wb.npc_wb;
      default: src_data = wb.alu_out_wb;
    endcase
    do_write = capture && (sel != WB_NONE) && (rd != '0);
  end

  // Stage the write; address/data hold when nothing new is written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      halted      <= 1'b0;
      retired_cnt <= '0;
    end else begin
      wr_en <= 1'b0;
      if (capture) begin
        retired_cnt <= retired_cnt + CNT_W'(1);
        if (op == OP_HLT) halted <= 1'b1;
        if (do_write) begin
          wr_en   <= 1'b1;
          wr_addr <= rd;
          wr_data <= src_data;
        end
      end
    end
  end

  regbank_3r1w #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_bank (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (wr_en),
    .waddr  (wr_addr),
    .wdata  (wr_data),
    .raddr0 (rs1_addr),
    .raddr1 (rs2_addr),
    .raddr2 (rd_addr),
    .rdata0 (a_data),
    .rdata1 (b_data),
    .rdata2 (d_data)
  );

endmodule
